// File: rtl/fir_tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tdm_pkg
//  Description : Shared types and elaboration-time helpers for the
//                time-multiplexed multi-channel FIR filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_tdm_pkg;

    // Controller states; the encoding is fixed so debug probes decode it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Accumulator wide enough for N_TAPS full-scale products with no overflow.
    function automatic int acc_width(int dw, int cw, int n_taps);
        return dw + cw + $clog2(n_taps);
    endfunction

    // Tap address width; never narrower than one bit.
    function automatic int addr_width(int n_taps);
        return (n_taps > 1) ? $clog2(n_taps) : 1;
    endfunction

    // Reset value of coef[0]: unity gain (2^shift), clamped to the largest
    // positive coefficient when unity is not representable.
    function automatic logic [63:0] reset_coef(int cw, int shift);
        if (shift >= cw - 1)
            return (64'd1 << (cw - 1)) - 64'd1;
        else
            return 64'd1 << shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tdm_filter_mac.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tdm_mac
//  Description : Registered signed multiply-accumulate with synchronous clear,
//                followed by a combinational round-half-up / saturate stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tdm_mac #(
    parameter int DW    = 12,
    parameter int CW    = 16,
    parameter int AW    = 32,
    parameter int SHIFT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] sample,
    input  logic signed [CW-1:0] coef,
    output logic signed [DW-1:0] result
);
    localparam int c_pw = DW + CW;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int c_rw = AW + 1;
    localparam logic signed [c_rw-1:0] c_half = (SHIFT > 0) ? (c_rw'(1) << (SHIFT - 1)) : '0;
    localparam logic signed [c_rw-1:0] c_max  = c_rw'(2 ** (DW - 1) - 1);
    localparam logic signed [c_rw-1:0] c_min  = c_rw'(-(2 ** (DW - 1)));

    logic signed [AW-1:0]   r_acc;
    logic signed [c_pw-1:0] w_prod;
    logic signed [c_rw-1:0] w_rnd;
    logic signed [c_rw-1:0] w_shr;

    assign w_prod = c_pw'(sample) * c_pw'(coef);
    assign w_rnd  = c_rw'(r_acc) + c_half;
    assign w_shr  = w_rnd >>> SHIFT;

    // Accumulate one product per enabled cycle; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_acc <= '0;
        else if (en)
            r_acc <= r_acc + AW'(w_prod);
    end

    // Clamp the rounded, scaled accumulator into the output sample range.
    always_comb begin
        result = w_shr[DW-1:0];
        if (w_shr > c_max)
            result = DW'(c_max);
        else if (w_shr < c_min)
            result = DW'(c_min);
    end

endmodule
`default_nettype wire

// File: rtl/fir_tdm_filter.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tdm_filter
//  Description : N_CH-channel FIR filter sharing one MAC in time. Per-channel
//                delay lines, run-time coefficient writes, bypass mode,
//                sticky overrun / coefficient-error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tdm_filter
    import fir_tdm_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int N_TAPS = 16,
    parameter int DW     = 12,
    parameter int CW     = 16,
    parameter int SHIFT  = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din_valid,
    input  logic [N_CH*DW-1:0]            din,
    input  logic                          mode,
    input  logic                          coef_we,
    input  logic [addr_width(N_TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]                 coef_wdata,
    output logic                          busy,
    output logic                          dout_valid,
    output logic [N_CH*DW-1:0]            dout,
    output logic                          overrun,
    output logic                          coef_err
);
    localparam int c_aw   = addr_width(N_TAPS);
    localparam int c_chw  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_accw = acc_width(DW, CW, N_TAPS);
    localparam logic signed [CW-1:0] c_coef_rst = CW'(reset_coef(CW, SHIFT));
    localparam logic [c_aw-1:0]      c_last_tap = c_aw'(N_TAPS - 1);
    localparam logic [c_chw-1:0]     c_last_ch  = c_chw'(N_CH - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DW-1:0] r_hist  [N_CH][N_TAPS];
    logic signed [CW-1:0] r_coef  [N_TAPS];
    logic signed [DW-1:0] r_stage [N_CH];
    logic [c_chw-1:0]     r_ch;
    logic [c_aw-1:0]      r_tap;
    logic                 r_busy;
    logic                 r_dout_valid;
    logic [N_CH*DW-1:0]   r_dout;
    logic                 r_overrun;
    logic                 r_coef_err;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_last_tap;
    logic                 w_last_ch;
    logic                 w_acc_clr;
    logic                 w_acc_en;
    logic signed [DW-1:0] w_mac_sample;
    logic signed [CW-1:0] w_mac_coef;
    logic signed [DW-1:0] w_result;

    // A strobe is only taken in IDLE; any other cycle (including the final
    // OUT cycle) counts as busy and the sample is dropped.
    assign w_accept     = din_valid && (r_state == IDLE) && !r_busy;
    assign w_start      = w_accept && !mode;
    assign w_last_tap   = (r_tap == c_last_tap);
    assign w_last_ch    = (r_ch == c_last_ch);
    assign w_mac_sample = r_hist[r_ch][r_tap];
    assign w_mac_coef   = r_coef[r_tap];

    assign busy       = r_busy;
    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign overrun    = r_overrun;
    assign coef_err   = r_coef_err;

    fir_tdm_mac #(
        .DW    (DW),
        .CW    (CW),
        .AW    (c_accw),
        .SHIFT (SHIFT)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_acc_clr),
        .en     (w_acc_en),
        .sample (w_mac_sample),
        .coef   (w_mac_coef),
        .result (w_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and MAC control; the accumulator is held clear outside MAC.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            IDLE: begin
                w_acc_clr = 1'b1;
                if (w_start)
                    w_state_nxt = MAC;
            end
            MAC: begin
                w_acc_en = 1'b1;
                if (w_last_tap)
                    w_state_nxt = OUT;
            end
            OUT: begin
                w_acc_clr   = 1'b1;
                w_state_nxt = w_last_ch ? IDLE : MAC;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Delay lines, coefficients, channel/tap counters, outputs and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int k = 0; k < N_TAPS; k++)
                    r_hist[c][k] <= '0;
                r_stage[c] <= '0;
            end
            for (int k = 0; k < N_TAPS; k++)
                r_coef[k] <= (k == 0) ? c_coef_rst : '0;
            r_ch         <= '0;
            r_tap        <= '0;
            r_busy       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_overrun    <= 1'b0;
            r_coef_err   <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;

            if (w_accept) begin
                for (int c = 0; c < N_CH; c++) begin
                    for (int k = N_TAPS - 1; k > 0; k--)
                        r_hist[c][k] <= r_hist[c][k-1];
                    r_hist[c][0] <= din[c*DW +: DW];
                end
                if (mode) begin
                    r_dout       <= din;
                    r_dout_valid <= 1'b1;
                end else begin
                    r_ch   <= '0;
                    r_tap  <= '0;
                    r_busy <= 1'b1;
                end
            end else if (din_valid) begin
                r_overrun <= 1'b1;
            end

            // Writes land on this edge, so a same-cycle sample already sees them.
            if (coef_we) begin
                if ((r_state == IDLE) && !r_busy && (coef_addr <= c_last_tap))
                    r_coef[coef_addr] <= coef_wdata;
                else
                    r_coef_err <= 1'b1;
            end

            case (r_state)
                MAC: begin
                    if (!w_last_tap)
                        r_tap <= r_tap + c_aw'(1);
                end
                OUT: begin
                    if (w_last_ch) begin
                        // Publish every channel at once from the staged results.
                        for (int c = 0; c < N_CH; c++)
                            r_dout[c*DW +: DW] <= (c_chw'(c) == r_ch) ? w_result : r_stage[c];
                        r_dout_valid <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_stage[r_ch] <= w_result;
                        r_ch          <= r_ch + c_chw'(1);
                        r_tap         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_tdm_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_tdm_filter
//  Description : Self-checking bench for fir_tdm_filter against an
//                arithmetic reference model of the filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_tdm_filter;
    localparam int N_CH   = 2;
    localparam int N_TAPS = 16;
    localparam int DW     = 12;
    localparam int CW     = 16;
    localparam int SHIFT  = 15;
    localparam int LAT    = N_CH * (N_TAPS + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               din_valid;
    logic [N_CH*DW-1:0] din;
    logic               mode;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic [CW-1:0]      coef_wdata;
    logic               busy;
    logic               dout_valid;
    logic [N_CH*DW-1:0] dout;
    logic               overrun;
    logic               coef_err;

    int errors = 0;
    int checks = 0;

    longint m_coef [N_TAPS];
    longint m_hist [N_CH][N_TAPS];

    fir_tdm_filter #(
        .N_CH(N_CH), .N_TAPS(N_TAPS), .DW(DW), .CW(CW), .SHIFT(SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .mode       (mode),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .busy       (busy),
        .dout_valid (dout_valid),
        .dout       (dout),
        .overrun    (overrun),
        .coef_err   (coef_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int k = 0; k < N_TAPS; k++) m_coef[k] = 0;
        for (int c = 0; c < N_CH; c++)
            for (int k = 0; k < N_TAPS; k++) m_hist[c][k] = 0;
        m_coef[0] = 2 ** SHIFT;
        if (m_coef[0] > 2 ** (CW - 1) - 1) m_coef[0] = 2 ** (CW - 1) - 1;
    endfunction

    function automatic void m_push(logic [N_CH*DW-1:0] v);
        for (int c = 0; c < N_CH; c++) begin
            for (int k = N_TAPS - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = longint'($signed(v[c*DW +: DW]));
        end
    endfunction

    // Sum of products, round half toward +inf, clamp to DW bits.
    function automatic int m_out(int c);
        longint acc = 0;
        for (int k = 0; k < N_TAPS; k++) acc += m_hist[c][k] * m_coef[k];
        acc = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (acc > 2047) acc = 2047;
        if (acc < -2048) acc = -2048;
        return int'(acc);
    endfunction

    function automatic logic [N_CH*DW-1:0] pack(int a, int b);
        logic [N_CH*DW-1:0] v;
        v[DW-1:0]    = a[DW-1:0];
        v[2*DW-1:DW] = b[DW-1:0];
        return v;
    endfunction

    function automatic int dout_ch(int c);
        return int'($signed(dout[c*DW +: DW]));
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(int addr, int val);
        coef_we    = 1'b1;
        coef_addr  = addr[3:0];
        coef_wdata = val[CW-1:0];
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic send(int a, int b, bit md);
        din       = pack(a, b);
        mode      = md;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        mode      = 1'b0;
        m_push(pack(a, b));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!dout_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_reset();
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({overrun, coef_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {overrun, coef_err}); end
    endtask

    task automatic test_identity(string tag);
        int n;
        send(100, -200, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_high: got %b expected 1", tag, busy); end
        wait_valid(n);
        checks++; if (n !== LAT) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", tag, n, LAT); end
        checks++; if (dout_ch(0) !== 100) begin errors++; $display("FAIL %s_ch0: got %0d expected 100", tag, dout_ch(0)); end
        checks++; if (dout_ch(1) !== -200) begin errors++; $display("FAIL %s_ch1: got %0d expected -200", tag, dout_ch(1)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_low: got %b expected 0", tag, busy); end
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL %s_pulse_width: got %b expected 0", tag, dout_valid); end
        checks++; if (dout_ch(0) !== 100) begin errors++; $display("FAIL %s_hold: got %0d expected 100", tag, dout_ch(0)); end
    endtask

    task automatic test_rounding();
        int vin [3]  = '{3, -3, 1};
        int vexp [3] = '{2, -1, 1};
        int n;
        write_coef(0, 16384);
        m_coef[0] = 16384;
        for (int i = 0; i < 3; i++) begin
            send(vin[i], -vin[i], 1'b0);
            wait_valid(n);
            checks++; if (n !== LAT) begin errors++; $display("FAIL round_latency: got %0d expected %0d", n, LAT); end
            checks++; if (dout_ch(0) !== vexp[i]) begin errors++; $display("FAIL round_ch0 in=%0d: got %0d expected %0d", vin[i], dout_ch(0), vexp[i]); end
            checks++; if (dout_ch(1) !== m_out(1)) begin errors++; $display("FAIL round_ch1: got %0d expected %0d", dout_ch(1), m_out(1)); end
        end
    endtask

    task automatic test_impulse();
        int n;
        int exp0;
        for (int k = 0; k < N_TAPS; k++) begin
            write_coef(k, 1024 * k);
            m_coef[k] = 1024 * k;
        end
        for (int i = 0; i < N_TAPS; i++) begin
            send(0, 0, 1'b0);
            wait_valid(n);
        end
        for (int j = 0; j <= N_TAPS; j++) begin
            send((j == 0) ? 2047 : 0, 0, 1'b0);
            wait_valid(n);
            exp0 = (j < N_TAPS) ? (2047 * j + 16) / 32 : 0;
            checks++; if (n !== LAT) begin errors++; $display("FAIL impulse_latency: got %0d expected %0d", n, LAT); end
            checks++; if (dout_ch(0) !== exp0) begin errors++; $display("FAIL impulse_ch0 k=%0d: got %0d expected %0d", j, dout_ch(0), exp0); end
            checks++; if (dout_ch(0) !== m_out(0)) begin errors++; $display("FAIL impulse_model k=%0d: got %0d expected %0d", j, dout_ch(0), m_out(0)); end
        end
    endtask

    task automatic test_saturation();
        int n;
        for (int k = 0; k < N_TAPS; k++) begin
            write_coef(k, 32767);
            m_coef[k] = 32767;
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < N_TAPS; i++) begin
                send(pass == 0 ? 2047 : -2048, pass == 0 ? -2048 : 2047, 1'b0);
                wait_valid(n);
                checks++; if (dout_ch(0) !== m_out(0)) begin errors++; $display("FAIL sat_model i=%0d: got %0d expected %0d", i, dout_ch(0), m_out(0)); end
            end
            checks++; if (dout_ch(0) !== (pass == 0 ? 2047 : -2048)) begin errors++; $display("FAIL sat_ch0 pass=%0d: got %0d expected %0d", pass, dout_ch(0), pass == 0 ? 2047 : -2048); end
            checks++; if (dout_ch(1) !== (pass == 0 ? -2048 : 2047)) begin errors++; $display("FAIL sat_ch1 pass=%0d: got %0d expected %0d", pass, dout_ch(1), pass == 0 ? -2048 : 2047); end
        end
    endtask

    task automatic test_overrun();
        int n;
        for (int k = 0; k < N_TAPS; k++) begin
            m_coef[k] = int'($urandom_range(8000)) - 4000;
            write_coef(k, int'(m_coef[k]));
        end
        send(rnd_sample(), rnd_sample(), 1'b0);
        repeat (4) tick();
        din = pack(rnd_sample(), rnd_sample());
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy: got %b expected 1", busy); end
        wait_valid(n);
        checks++; if (n + 5 !== LAT) begin errors++; $display("FAIL overrun_latency: got %0d expected %0d", n + 5, LAT); end
        for (int c = 0; c < N_CH; c++) begin
            checks++; if (dout_ch(c) !== m_out(c)) begin errors++; $display("FAIL overrun_result ch%0d: got %0d expected %0d", c, dout_ch(c), m_out(c)); end
        end
        // Next strobe right after the pulse must be accepted.
        send(rnd_sample(), rnd_sample(), 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_next_accept: got %b expected 1", busy); end
        // A strobe on the final OUT edge is dropped as well.
        repeat (LAT - 1) tick();
        din = pack(rnd_sample(), rnd_sample());
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL out_edge_valid: got %b expected 1", dout_valid); end
        for (int c = 0; c < N_CH; c++) begin
            checks++; if (dout_ch(c) !== m_out(c)) begin errors++; $display("FAIL out_edge_result ch%0d: got %0d expected %0d", c, dout_ch(c), m_out(c)); end
        end
        send(rnd_sample(), rnd_sample(), 1'b0);
        wait_valid(n);
        for (int c = 0; c < N_CH; c++) begin
            checks++; if (dout_ch(c) !== m_out(c)) begin errors++; $display("FAIL out_edge_history ch%0d: got %0d expected %0d", c, dout_ch(c), m_out(c)); end
        end
    endtask

    task automatic test_coef_err();
        int n;
        for (int k = 0; k < N_TAPS; k++) begin
            write_coef(k, (k == 3) ? 5000 : 0);
            m_coef[k] = (k == 3) ? 5000 : 0;
        end
        send(rnd_sample(), rnd_sample(), 1'b0);
        repeat (3) tick();
        coef_we    = 1'b1;
        coef_addr  = 4'd3;
        coef_wdata = 16'(-7000);
        tick();
        coef_we    = 1'b0;
        checks++; if (coef_err !== 1'b1) begin errors++; $display("FAIL coef_err_flag: got %b expected 1", coef_err); end
        wait_valid(n);
        checks++; if (n + 4 !== LAT) begin errors++; $display("FAIL coef_err_latency: got %0d expected %0d", n + 4, LAT); end
        for (int i = 0; i < 4; i++) begin
            send(i == 0 ? 2000 : 0, i == 0 ? -2000 : 0, 1'b0);
            wait_valid(n);
            for (int c = 0; c < N_CH; c++) begin
                checks++; if (dout_ch(c) !== m_out(c)) begin errors++; $display("FAIL coef_unchanged i=%0d ch%0d: got %0d expected %0d", i, c, dout_ch(c), m_out(c)); end
            end
        end
        // Write and strobe together: the new coefficient is used immediately.
        coef_we    = 1'b1;
        coef_addr  = 4'd0;
        coef_wdata = 16'd9000;
        m_coef[0]  = 9000;
        send(1500, -1500, 1'b0);
        coef_we    = 1'b0;
        wait_valid(n);
        checks++; if (dout_ch(0) !== m_out(0)) begin errors++; $display("FAIL coef_same_cycle: got %0d expected %0d", dout_ch(0), m_out(0)); end
    endtask

    task automatic test_bypass();
        int n;
        write_coef(1, 16384);
        m_coef[1] = 16384;
        send(-77, 55, 1'b1);
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b expected 1", dout_valid); end
        checks++; if (dout_ch(0) !== -77) begin errors++; $display("FAIL bypass_ch0: got %0d expected -77", dout_ch(0)); end
        checks++; if (dout_ch(1) !== 55) begin errors++; $display("FAIL bypass_ch1: got %0d expected 55", dout_ch(1)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bypass_busy: got %b expected 0", busy); end
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL bypass_pulse: got %b expected 0", dout_valid); end
        send(1000, -1000, 1'b0);
        wait_valid(n);
        checks++; if (n !== LAT) begin errors++; $display("FAIL bypass_filter_latency: got %0d expected %0d", n, LAT); end
        for (int c = 0; c < N_CH; c++) begin
            checks++; if (dout_ch(c) !== m_out(c)) begin errors++; $display("FAIL bypass_history ch%0d: got %0d expected %0d", c, dout_ch(c), m_out(c)); end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        send(rnd_sample(), rnd_sample(), 1'b0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 2 * LAT; i++) begin
            if (dout_valid) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_no_valid: got %0d expected 0", pulses); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL midreset_dout: got %h expected 0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if ({overrun, coef_err} !== 2'b00) begin errors++; $display("FAIL midreset_flags: got %b expected 00", {overrun, coef_err}); end
        test_identity("midreset");
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 12; i++) begin
            for (int w = 0; w < 3; w++) begin
                int a = int'($urandom_range(N_TAPS - 1));
                m_coef[a] = int'($urandom_range(65535)) - 32768;
                write_coef(a, int'(m_coef[a]));
            end
            send(rnd_sample(), rnd_sample(), 1'b0);
            wait_valid(n);
            checks++; if (n !== LAT) begin errors++; $display("FAIL random_latency: got %0d expected %0d", n, LAT); end
            for (int c = 0; c < N_CH; c++) begin
                checks++; if (dout_ch(c) !== m_out(c)) begin errors++; $display("FAIL random i=%0d ch%0d: got %0d expected %0d", i, c, dout_ch(c), m_out(c)); end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        mode       = 1'b0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        test_reset();
        test_identity("identity");
        test_rounding();
        test_impulse();
        test_saturation();
        test_overrun();
        test_coef_err();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
